// File: rtl/muldiv_if.sv
// EX-stage <-> multiply/divide sequencer handshake bundle.
// Optional signal div_by_zero exists only when MULDIV_DIV0_FAST_EN is defined.
// master: EX stage side (issues operations); slave: muldiv_ctrl.
interface muldiv_if;
    logic        op_valid;
    logic [1:0]  op_code;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        annul;
    logic        ex_hold;
    logic        stallreq;
    logic        busy;
    logic        result_valid;
    logic [31:0] result_hi;
    logic [31:0] result_lo;
`ifdef MULDIV_DIV0_FAST_EN
    logic        div_by_zero;
`endif

    modport master (
`ifdef MULDIV_DIV0_FAST_EN
        input  div_by_zero,
`endif
        output op_valid,
        output op_code,
        output op_a,
        output op_b,
        output annul,
        output ex_hold,
        input  stallreq,
        input  busy,
        input  result_valid,
        input  result_hi,
        input  result_lo
    );

    modport slave (
`ifdef MULDIV_DIV0_FAST_EN
        output div_by_zero,
`endif
        input  op_valid,
        input  op_code,
        input  op_a,
        input  op_b,
        input  annul,
        input  ex_hold,
        output stallreq,
        output busy,
        output result_valid,
        output result_hi,
        output result_lo
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer shared by the EX stage.
// Multiplies complete MUL_LAT cycles after accept, divides 33 cycles after accept
// (32 restoring shift-subtract steps). The result is held in DONE while ex_hold is high.
// Optional feature MULDIV_DIV0_FAST_EN: a zero divisor bypasses the divider and
// finishes one cycle after accept, flagged on div_by_zero.
module muldiv_ctrl #(
    parameter int unsigned MUL_LAT   = 4,
    parameter int unsigned DIV_STEPS = 32
) (
    input logic     clk,
    input logic     rst,
    muldiv_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e      state_q;
    logic [4:0]  cnt_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        a_sign_q;
    logic        b_sign_q;
    logic        signed_q;
    logic [63:0] rq_q;
    logic        res_valid_q;
    logic [31:0] res_hi_q;
    logic [31:0] res_lo_q;
`ifdef MULDIV_DIV0_FAST_EN
    logic        dbz_q;
`endif

    logic        in_signed;
    logic [31:0] in_a_mag;
    logic [31:0] in_b_mag;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_neg;
    logic [63:0] product;
    logic [63:0] mul_res;
    logic [32:0] rem_shift;
    logic [32:0] diff;
    logic [63:0] step_rq;
    logic [63:0] div_fin;
    logic [63:0] div0_res;
    logic        accept;
    logic        abort;
    logic        div0_fast;

    // Signed fix-up: quotient negated when signs differ, remainder follows the dividend.
    // Returns {remainder, quotient}.
    function automatic logic [63:0] div_fix(input logic [31:0] q, input logic [31:0] r,
                                            input logic sgn, input logic sa, input logic sb);
        logic [31:0] qf;
        logic [31:0] rf;
        qf = (sgn && (sa ^ sb)) ? -q : q;
        rf = (sgn && sa) ? -r : r;
        return {rf, qf};
    endfunction

    // Operand magnitudes, shared multiplier, one division step and fix-ups.
    always_comb begin
        in_signed = ~bus.op_code[0];
        in_a_mag  = (in_signed && bus.op_a[31]) ? -bus.op_a : bus.op_a;
        in_b_mag  = (in_signed && bus.op_b[31]) ? -bus.op_b : bus.op_b;

        // In IDLE the multiplier sees live operands so MUL_LAT=1 can finish from accept.
        if (state_q == StIdle) begin
            mul_a   = in_a_mag;
            mul_b   = in_b_mag;
            mul_neg = in_signed & (bus.op_a[31] ^ bus.op_b[31]);
        end else begin
            mul_a   = a_q;
            mul_b   = b_q;
            mul_neg = signed_q & (a_sign_q ^ b_sign_q);
        end
        product = {32'd0, mul_a} * {32'd0, mul_b};
        mul_res = mul_neg ? -product : product;

        // Partial remainder can reach 33 bits after the shift; diff[32] is the borrow.
        rem_shift = rq_q[63:31];
        diff      = rem_shift - {1'b0, b_q};
        step_rq   = diff[32] ? {rq_q[62:0], 1'b0} : {diff[31:0], rq_q[30:0], 1'b1};

        div_fin  = div_fix(step_rq[31:0], step_rq[63:32], signed_q, a_sign_q, b_sign_q);
        // Unsigned divide-by-zero result is quotient all-ones, remainder |dividend|.
        div0_res = div_fix(32'hFFFF_FFFF, in_a_mag, in_signed, bus.op_a[31], bus.op_b[31]);

        accept = (state_q == StIdle) && bus.op_valid && !bus.annul;
        abort  = bus.annul || (((state_q == StMul) || (state_q == StDiv)) && !bus.op_valid);
`ifdef MULDIV_DIV0_FAST_EN
        div0_fast = (bus.op_b == 32'd0);
`else
        div0_fast = 1'b0;
`endif
    end

    // Sequencer FSM with registered operands, datapath state and results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 5'd0;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            a_sign_q    <= 1'b0;
            b_sign_q    <= 1'b0;
            signed_q    <= 1'b0;
            rq_q        <= 64'd0;
            res_valid_q <= 1'b0;
            res_hi_q    <= 32'd0;
            res_lo_q    <= 32'd0;
`ifdef MULDIV_DIV0_FAST_EN
            dbz_q       <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        a_q      <= in_a_mag;
                        b_q      <= in_b_mag;
                        a_sign_q <= bus.op_a[31];
                        b_sign_q <= bus.op_b[31];
                        signed_q <= in_signed;
                        if (!bus.op_code[1]) begin
                            if (MUL_LAT <= 1) begin
                                state_q     <= StDone;
                                res_valid_q <= 1'b1;
                                res_hi_q    <= mul_res[63:32];
                                res_lo_q    <= mul_res[31:0];
                            end else begin
                                state_q <= StMul;
                                // Accept cycle counts as the first of MUL_LAT cycles.
                                cnt_q   <= 5'(MUL_LAT - 2);
                            end
                        end else if (div0_fast) begin
                            state_q     <= StDone;
                            res_valid_q <= 1'b1;
                            res_hi_q    <= div0_res[63:32];
                            res_lo_q    <= div0_res[31:0];
`ifdef MULDIV_DIV0_FAST_EN
                            dbz_q       <= 1'b1;
`endif
                        end else begin
                            state_q <= StDiv;
                            cnt_q   <= 5'(DIV_STEPS - 1);
                            rq_q    <= {32'd0, in_a_mag};
                        end
                    end
                end
                StMul: begin
                    if (abort) begin
                        state_q <= StIdle;
                    end else if (cnt_q == 5'd0) begin
                        state_q     <= StDone;
                        res_valid_q <= 1'b1;
                        res_hi_q    <= mul_res[63:32];
                        res_lo_q    <= mul_res[31:0];
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                StDiv: begin
                    if (abort) begin
                        state_q <= StIdle;
                    end else begin
                        rq_q <= step_rq;
                        if (cnt_q == 5'd0) begin
                            state_q     <= StDone;
                            res_valid_q <= 1'b1;
                            res_hi_q    <= div_fin[63:32];
                            res_lo_q    <= div_fin[31:0];
                        end else begin
                            cnt_q <= cnt_q - 5'd1;
                        end
                    end
                end
                StDone: begin
                    if (bus.annul || !bus.ex_hold) begin
                        state_q     <= StIdle;
                        res_valid_q <= 1'b0;
`ifdef MULDIV_DIV0_FAST_EN
                        dbz_q       <= 1'b0;
`endif
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.stallreq     = bus.op_valid & ~bus.annul & (state_q != StDone);
    assign bus.busy         = (state_q != StIdle);
    assign bus.result_valid = res_valid_q;
    assign bus.result_hi    = res_hi_q;
    assign bus.result_lo    = res_lo_q;
`ifdef MULDIV_DIV0_FAST_EN
    assign bus.div_by_zero  = dbz_q;
`endif

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: latency, stall, signed fix-ups, divide by zero,
// annul, hold and mid-operation reset.
module tb_muldiv_ctrl;
    localparam int unsigned MUL_LAT = 4;
`ifdef MULDIV_DIV0_FAST_EN
    localparam int DIV0_LAT = 1;
`else
    localparam int DIV0_LAT = 33;
`endif

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    muldiv_if bus ();

    muldiv_ctrl #(
        .MUL_LAT  (MUL_LAT),
        .DIV_STEPS(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op, hold op_valid until the result, check stall every cycle, then retire.
    task automatic run_op(input string tag, input logic [1:0] code, input logic [31:0] a,
                          input logic [31:0] b, input int lat,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        @(posedge clk); #1;
        bus.op_valid = 1'b1;
        bus.op_code  = code;
        bus.op_a     = a;
        bus.op_b     = b;
        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            check({tag, " stallreq"}, 32'(bus.stallreq), 32'd1);
            check({tag, " valid_early"}, 32'(bus.result_valid), 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check({tag, " valid"}, 32'(bus.result_valid), 32'd1);
        check({tag, " stallreq_done"}, 32'(bus.stallreq), 32'd0);
        check({tag, " hi"}, bus.result_hi, exp_hi);
        check({tag, " lo"}, bus.result_lo, exp_lo);
`ifdef MULDIV_DIV0_FAST_EN
        check({tag, " dbz"}, 32'(bus.div_by_zero), 32'((code[1] == 1'b1) && (b == 32'd0)));
`endif
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        @(negedge clk);
        check({tag, " idle_busy"}, 32'(bus.busy), 32'd0);
        check({tag, " idle_valid"}, 32'(bus.result_valid), 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        bus.op_valid = 1'b0;
        bus.op_code  = 2'b00;
        bus.op_a     = 32'd0;
        bus.op_b     = 32'd0;
        bus.annul    = 1'b0;
        bus.ex_hold  = 1'b0;

        // Reset state
        @(posedge clk);
        @(negedge clk);
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst valid", 32'(bus.result_valid), 32'd0);
        check("rst stallreq", 32'(bus.stallreq), 32'd0);
        check("rst hi", bus.result_hi, 32'd0);
        check("rst lo", bus.result_lo, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_op("divu 100/7", 2'b11, 32'd100, 32'd7, 33, 32'd2, 32'd14);
        run_op("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 33, 32'd1, 32'hFFFF_FFFD);
        run_op("div min/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000);
        run_op("mult -1*2", 2'b00, 32'hFFFF_FFFF, 32'd2, MUL_LAT, 32'hFFFF_FFFF,
               32'hFFFF_FFFE);
        run_op("multu ffffffff*2", 2'b01, 32'hFFFF_FFFF, 32'd2, MUL_LAT, 32'd1,
               32'hFFFF_FFFE);
        run_op("divu 5/0", 2'b11, 32'd5, 32'd0, DIV0_LAT, 32'd5, 32'hFFFF_FFFF);

        // Annul a divide mid-flight
        @(posedge clk); #1;
        bus.op_valid = 1'b1;
        bus.op_code  = 2'b10;
        bus.op_a     = 32'd100;
        bus.op_b     = 32'd7;
        repeat (10) @(posedge clk);
        #1;
        bus.annul = 1'b1;
        @(negedge clk);
        check("annul stallreq", 32'(bus.stallreq), 32'd0);
        check("annul busy_before", 32'(bus.busy), 32'd1);
        @(posedge clk); #1;
        bus.annul    = 1'b0;
        bus.op_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("annul busy_after", 32'(bus.busy), 32'd0);
            check("annul valid", 32'(bus.result_valid), 32'd0);
        end
        run_op("divu 9/3", 2'b11, 32'd9, 32'd3, 33, 32'd0, 32'd3);

        // Result held while the downstream pipeline stalls
        @(posedge clk); #1;
        bus.op_valid = 1'b1;
        bus.op_code  = 2'b01;
        bus.op_a     = 32'd3;
        bus.op_b     = 32'd5;
        bus.ex_hold  = 1'b1;
        repeat (MUL_LAT) @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold valid", 32'(bus.result_valid), 32'd1);
            check("hold hi", bus.result_hi, 32'd0);
            check("hold lo", bus.result_lo, 32'd15);
            check("hold busy", 32'(bus.busy), 32'd1);
            @(posedge clk); #1;
        end
        bus.ex_hold = 1'b0;
        @(negedge clk);
        check("hold release valid", 32'(bus.result_valid), 32'd1);
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        @(negedge clk);
        check("hold exit busy", 32'(bus.busy), 32'd0);
        check("hold exit valid", 32'(bus.result_valid), 32'd0);
        check("hold keep lo", bus.result_lo, 32'd15);

        // Reset mid-operation clears everything
        @(posedge clk); #1;
        bus.op_valid = 1'b1;
        bus.op_code  = 2'b00;
        bus.op_a     = 32'd5;
        bus.op_b     = 32'd6;
        repeat (2) @(posedge clk);
        #1;
        rst          = 1'b1;
        bus.op_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst busy", 32'(bus.busy), 32'd0);
        check("midrst valid", 32'(bus.result_valid), 32'd0);
        check("midrst hi", bus.result_hi, 32'd0);
        check("midrst lo", bus.result_lo, 32'd0);
        repeat (MUL_LAT + 1) @(negedge clk);
        check("midrst no result", 32'(bus.result_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
